// File: rtl/tx_arb3.sv
// tx_arb3 -- frame-granular round-robin arbiter: three FWFT forwarding
// queues share one XGMII TX port.
//
// Optional feature macro: TXARB_STATS_EN (builds the statistics counters
// frame_cnt / abort_cnt / discard_cnt and their ports).
//
// Ports
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   tx_en                1 = new grants allowed (registered before use)
//   qN_dout / qN_empty   FWFT head word {txc[7:0], txd[63:0]} and empty flag
//   qN_rd_en             pop strobe (combinational from state and empty)
//   xgmii_txd/xgmii_txc  registered TX bus
//   grant                port being served, 3 = none
//   frame_cnt            frames sent, wraps           (TXARB_STATS_EN)
//   abort_cnt            underrun aborts, saturates   (TXARB_STATS_EN)
//   discard_cnt          non-SOF heads, saturates     (TXARB_STATS_EN)
//   dbg_state            FSM state: 0 IDLE, 1 SEND, 2 DRAIN, 3 IFG
//
// Handshake: a queue is popped in a cycle exactly when its rd_en is high
// while its empty flag is low; the popped word appears on the bus one
// cycle later. At most one rd_en is high per cycle.
module tx_arb3 #(
  parameter int unsigned IFG_WORDS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [71:0] q0_dout,
  input  logic [71:0] q1_dout,
  input  logic [71:0] q2_dout,
  input  logic        q0_empty,
  input  logic        q1_empty,
  input  logic        q2_empty,
  output logic        q0_rd_en,
  output logic        q1_rd_en,
  output logic        q2_rd_en,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  grant,
`ifdef TXARB_STATS_EN
  output logic [31:0] frame_cnt,
  output logic [15:0] abort_cnt,
  output logic [15:0] discard_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [71:0] IDLE_WORD = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_WORD  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
  // IFG state lasts IFG_WORDS cycles; the counter counts down to zero.
  localparam logic [3:0]  IFG_LOAD  = (IFG_WORDS == 0) ? 4'd0 : 4'(IFG_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_IFG   = 2'd3
  } state_t;

  function automatic logic is_sof(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_eof(input logic [71:0] w);
    logic r;
    r = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (w[64 + j] && (w[8*j +: 8] == 8'hFD)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  state_t      r_state, w_state_n;
  logic [1:0]  r_ptr, w_ptr_n;
  logic [1:0]  r_grant, w_grant_n;
  logic [3:0]  r_ifg_cnt, w_ifg_n;
  logic        r_tx_en;
  logic [71:0] r_bus, w_bus_n;

  // Index 3 is the "no port" slot: always empty, drives the idle word.
  logic [3:0]  w_empty;
  logic [71:0] w_dout [4];
  logic [1:0]  w_cand;
  logic        w_cand_vld;
  logic [71:0] w_head;
  logic [71:0] w_gword;
  logic        w_pop;
  logic [1:0]  w_pop_port;
  logic        w_done;

  assign w_empty   = {1'b1, q2_empty, q1_empty, q0_empty};
  assign w_dout[0] = q0_dout;
  assign w_dout[1] = q1_dout;
  assign w_dout[2] = q2_dout;
  assign w_dout[3] = IDLE_WORD;

  // Candidate: first non-empty queue in order ptr, ptr+1, ptr+2.
  always_comb begin
    logic [1:0] p1, p2;
    p1         = inc3(r_ptr);
    p2         = inc3(p1);
    w_cand     = r_ptr;
    w_cand_vld = 1'b1;
    if (!w_empty[r_ptr])   w_cand = r_ptr;
    else if (!w_empty[p1]) w_cand = p1;
    else if (!w_empty[p2]) w_cand = p2;
    else                   w_cand_vld = 1'b0;
  end

  assign w_head  = w_dout[w_cand];
  assign w_gword = w_dout[r_grant];

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_grant_n  = r_grant;
    w_ifg_n    = r_ifg_cnt;
    w_bus_n    = IDLE_WORD;
    w_pop      = 1'b0;
    w_pop_port = r_grant;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tx_en && w_cand_vld) begin
          w_pop      = 1'b1;
          w_pop_port = w_cand;
          if (is_sof(w_head)) begin
            w_bus_n = w_head;
            if (is_eof(w_head)) begin
              w_done = 1'b1;
            end else begin
              w_grant_n = w_cand;
              w_state_n = S_SEND;
            end
          end
          // A non-SOF head is popped and dropped; the bus stays idle.
        end
      end
      S_SEND: begin
        if (!w_empty[r_grant]) begin
          w_pop   = 1'b1;
          w_bus_n = w_gword;
          if (is_eof(w_gword)) w_done = 1'b1;
        end else begin
          // Underrun: poison the frame on the wire, then flush its remainder.
          w_bus_n   = ERR_WORD;
          w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_empty[r_grant]) begin
          w_pop = 1'b1;
          if (is_eof(w_gword)) w_done = 1'b1;
        end
      end
      S_IFG: begin
        if (r_ifg_cnt == 4'd0) w_state_n = S_IDLE;
        else                   w_ifg_n   = r_ifg_cnt - 4'd1;
      end
      default: w_state_n = S_IDLE;
    endcase
    // End of frame (sent or drained): advance the pointer past the port.
    if (w_done) begin
      w_ptr_n   = inc3(w_pop_port);
      w_grant_n = 2'd3;
      w_ifg_n   = IFG_LOAD;
      w_state_n = (IFG_WORDS == 0) ? S_IDLE : S_IFG;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd3;
      r_ifg_cnt <= 4'd0;
      r_tx_en   <= 1'b0;
      r_bus     <= IDLE_WORD;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_grant   <= w_grant_n;
      r_ifg_cnt <= w_ifg_n;
      r_tx_en   <= tx_en;
      r_bus     <= w_bus_n;
    end
  end

  assign q0_rd_en  = w_pop && (w_pop_port == 2'd0);
  assign q1_rd_en  = w_pop && (w_pop_port == 2'd1);
  assign q2_rd_en  = w_pop && (w_pop_port == 2'd2);
  assign xgmii_txc = r_bus[71:64];
  assign xgmii_txd = r_bus[63:0];
  assign grant     = r_grant;
  assign dbg_state = r_state;

`ifdef TXARB_STATS_EN
  logic        w_inc_frame, w_inc_abort, w_inc_discard;
  logic [31:0] r_frame_cnt;
  logic [15:0] r_abort_cnt, r_discard_cnt;

  assign w_inc_frame   = w_done && (r_state != S_DRAIN);
  assign w_inc_abort   = (r_state == S_SEND) && w_empty[r_grant];
  assign w_inc_discard = (r_state == S_IDLE) && w_pop && !is_sof(w_head);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frame_cnt   <= 32'd0;
      r_abort_cnt   <= 16'd0;
      r_discard_cnt <= 16'd0;
    end else begin
      if (w_inc_frame) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_inc_abort && (r_abort_cnt != 16'hFFFF))
        r_abort_cnt <= r_abort_cnt + 16'd1;
      if (w_inc_discard && (r_discard_cnt != 16'hFFFF))
        r_discard_cnt <= r_discard_cnt + 16'd1;
    end
  end

  assign frame_cnt   = r_frame_cnt;
  assign abort_cnt   = r_abort_cnt;
  assign discard_cnt = r_discard_cnt;
`endif

endmodule

// File: tb/tb_tx_arb3.sv
// Directed bench for tx_arb3 (IFG_WORDS = 1). Three FWFT queues are modelled
// as SystemVerilog queues; a pop happens at the clock edge when rd_en was
// high at the preceding negedge.
module tb_tx_arb3;
  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        tx_en;
  logic [71:0] q0_dout, q1_dout, q2_dout;
  logic        q0_empty, q1_empty, q2_empty;
  logic        q0_rd_en, q1_rd_en, q2_rd_en;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [1:0]  grant;
  logic [1:0]  dbg_state;
`ifdef TXARB_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] abort_cnt, discard_cnt;
`endif

  logic [71:0] fq0[$];
  logic [71:0] fq1[$];
  logic [71:0] fq2[$];
  logic [2:0]  rd_s;
  int          n_vec = 0;
  int          n_err = 0;

  tx_arb3 #(.IFG_WORDS(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en),
    .q0_dout(q0_dout), .q1_dout(q1_dout), .q2_dout(q2_dout),
    .q0_empty(q0_empty), .q1_empty(q1_empty), .q2_empty(q2_empty),
    .q0_rd_en(q0_rd_en), .q1_rd_en(q1_rd_en), .q2_rd_en(q2_rd_en),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .grant(grant),
`ifdef TXARB_STATS_EN
    .frame_cnt(frame_cnt), .abort_cnt(abort_cnt), .discard_cnt(discard_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  function automatic logic [71:0] sofw(input logic [7:0] id);
    return {8'h01, 48'h0, id, 8'hFB};
  endfunction
  function automatic logic [71:0] dataw(input logic [7:0] id, input logic [7:0] n);
    return {8'h00, 32'hDA7A0000, 8'h00, id, 8'h00, n};
  endfunction
  // Terminate in lane 3.
  function automatic logic [71:0] eofw(input logic [7:0] id);
    return {8'hF8, 32'h07070707, 8'hFD, 8'h00, id, 8'h55};
  endfunction

  task automatic upd();
    q0_empty = (fq0.size() == 0);
    q1_empty = (fq1.size() == 0);
    q2_empty = (fq2.size() == 0);
    q0_dout  = q0_empty ? IDLE_W : fq0[0];
    q1_dout  = q1_empty ? IDLE_W : fq1[0];
    q2_dout  = q2_empty ? IDLE_W : fq2[0];
  endtask

  task automatic push(input int p, input logic [71:0] w);
    case (p)
      0: fq0.push_back(w);
      1: fq1.push_back(w);
      default: fq2.push_back(w);
    endcase
  endtask

  task automatic tick();
    @(negedge sys_clk);
    rd_s = {q2_rd_en, q1_rd_en, q0_rd_en};
    @(posedge sys_clk);
    #1;
    if (rd_s[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (rd_s[1] && fq1.size() > 0) void'(fq1.pop_front());
    if (rd_s[2] && fq2.size() > 0) void'(fq2.pop_front());
    upd();
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] erd,
                      input logic [71:0] ebus, input logic [1:0] egr);
    tick();
    chk({tag, "/rd"}, 72'(rd_s), 72'(erd));
    chk({tag, "/bus"}, {xgmii_txc, xgmii_txd}, ebus);
    chk({tag, "/grant"}, 72'(grant), 72'(egr));
  endtask

  initial begin
    sys_rst = 1'b1;
    tx_en   = 1'b0;
    upd();
    #1;
    // reset state
    chk("rst_bus", {xgmii_txc, xgmii_txd}, IDLE_W);
    chk("rst_grant", 72'(grant), 72'(2'd3));
    chk("rst_rd", 72'({q2_rd_en, q1_rd_en, q0_rd_en}), 72'(3'b000));
    chk("rst_state", 72'(dbg_state), 72'(2'd0));
`ifdef TXARB_STATS_EN
    chk("rst_frame_cnt", 72'(frame_cnt), 72'(0));
    chk("rst_abort_cnt", 72'(abort_cnt), 72'(0));
    chk("rst_discard_cnt", 72'(discard_cnt), 72'(0));
`endif
    #23;
    sys_rst = 1'b0;

    // Fairness: two 3-word frames per queue, all preloaded.
    for (int fr = 0; fr < 2; fr++)
      for (int p = 0; p < 3; p++) begin
        push(p, sofw(8'(16*p + fr)));
        push(p, dataw(8'(16*p + fr), 8'd1));
        push(p, eofw(8'(16*p + fr)));
      end
    upd();
    step("en_off", 3'b000, IDLE_W, 2'd3);
    tx_en = 1'b1;
    step("en_sync", 3'b000, IDLE_W, 2'd3);
    for (int f = 0; f < 6; f++) begin
      int p;
      logic [7:0] id;
      p  = f % 3;
      id = 8'(16*p + f/3);
      step("fair_sof", 3'(1 << p), sofw(id), 2'(p));
      step("fair_data", 3'(1 << p), dataw(id, 8'd1), 2'(p));
      step("fair_eof", 3'(1 << p), eofw(id), 2'd3);
      step("fair_ifg", 3'b000, IDLE_W, 2'd3);
    end
`ifdef TXARB_STATS_EN
    chk("fair_frame_cnt", 72'(frame_cnt), 72'(6));
`endif

    // Latency: single frame in q1 only.
    push(1, sofw(8'h20)); push(1, dataw(8'h20, 8'd1)); push(1, eofw(8'h20));
    upd();
    step("lat_sof", 3'b010, sofw(8'h20), 2'd1);
    step("lat_data", 3'b010, dataw(8'h20, 8'd1), 2'd1);
    step("lat_eof", 3'b010, eofw(8'h20), 2'd3);
    step("lat_ifg", 3'b000, IDLE_W, 2'd3);
    step("lat_quiet", 3'b000, IDLE_W, 2'd3);

    // Underrun on q0 (ptr=2, q2 empty so q0 wins over waiting q1).
    push(0, sofw(8'h30)); push(0, dataw(8'h30, 8'd1));
    push(1, sofw(8'h31)); push(1, dataw(8'h31, 8'd1)); push(1, eofw(8'h31));
    upd();
    step("ur_sof", 3'b001, sofw(8'h30), 2'd0);
    step("ur_data", 3'b001, dataw(8'h30, 8'd1), 2'd0);
    step("ur_err", 3'b000, ERR_W, 2'd0);
    chk("ur_state_drain", 72'(dbg_state), 72'(2'd2));
`ifdef TXARB_STATS_EN
    chk("ur_abort_cnt", 72'(abort_cnt), 72'(1));
`endif
    for (int i = 0; i < 3; i++) step("ur_wait", 3'b000, IDLE_W, 2'd0);
    push(0, dataw(8'h30, 8'd2)); push(0, eofw(8'h30));
    upd();
    step("ur_drain_d", 3'b001, IDLE_W, 2'd0);
    step("ur_drain_eof", 3'b001, IDLE_W, 2'd3);
    chk("ur_q0_drained", 72'(fq0.size()), 72'(0));
    step("ur_ifg", 3'b000, IDLE_W, 2'd3);
    step("ur_next_sof", 3'b010, sofw(8'h31), 2'd1);
    step("ur_next_data", 3'b010, dataw(8'h31, 8'd1), 2'd1);
    step("ur_next_eof", 3'b010, eofw(8'h31), 2'd3);
    step("ur_next_ifg", 3'b000, IDLE_W, 2'd3);

    // Garbage head on q2 (ptr=2).
    push(2, dataw(8'h40, 8'd9));
    push(2, sofw(8'h41)); push(2, dataw(8'h41, 8'd1)); push(2, eofw(8'h41));
    upd();
    step("gb_discard", 3'b100, IDLE_W, 2'd3);
`ifdef TXARB_STATS_EN
    chk("gb_discard_cnt", 72'(discard_cnt), 72'(1));
`endif
    step("gb_sof", 3'b100, sofw(8'h41), 2'd2);
    step("gb_data", 3'b100, dataw(8'h41, 8'd1), 2'd2);
    step("gb_eof", 3'b100, eofw(8'h41), 2'd3);
    step("gb_ifg", 3'b000, IDLE_W, 2'd3);

    // tx_en dropped mid-frame on q0 while q1 waits (ptr=0).
    push(0, sofw(8'h50)); push(0, dataw(8'h50, 8'd1));
    push(0, dataw(8'h50, 8'd2)); push(0, eofw(8'h50));
    push(1, sofw(8'h51)); push(1, dataw(8'h51, 8'd1)); push(1, eofw(8'h51));
    upd();
    step("ten_sof", 3'b001, sofw(8'h50), 2'd0);
    tx_en = 1'b0;
    step("ten_d1", 3'b001, dataw(8'h50, 8'd1), 2'd0);
    step("ten_d2", 3'b001, dataw(8'h50, 8'd2), 2'd0);
    step("ten_eof", 3'b001, eofw(8'h50), 2'd3);
    step("ten_ifg", 3'b000, IDLE_W, 2'd3);
    for (int i = 0; i < 3; i++) step("ten_hold", 3'b000, IDLE_W, 2'd3);
    tx_en = 1'b1;
    step("ten_sync", 3'b000, IDLE_W, 2'd3);
    step("ten_q1_sof", 3'b010, sofw(8'h51), 2'd1);
    step("ten_q1_data", 3'b010, dataw(8'h51, 8'd1), 2'd1);
    step("ten_q1_eof", 3'b010, eofw(8'h51), 2'd3);
    step("ten_q1_ifg", 3'b000, IDLE_W, 2'd3);

    // Asynchronous reset at the second word of a q2 frame (ptr=2).
    push(2, sofw(8'h60)); push(2, dataw(8'h60, 8'd1));
    push(2, dataw(8'h60, 8'd2)); push(2, eofw(8'h60));
    upd();
    step("ar_sof", 3'b100, sofw(8'h60), 2'd2);
    step("ar_d1", 3'b100, dataw(8'h60, 8'd1), 2'd2);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("ar_bus_idle", {xgmii_txc, xgmii_txd}, IDLE_W);
    chk("ar_grant", 72'(grant), 72'(2'd3));
    chk("ar_rd", 72'({q2_rd_en, q1_rd_en, q0_rd_en}), 72'(3'b000));
`ifdef TXARB_STATS_EN
    chk("ar_frame_cnt", 72'(frame_cnt), 72'(0));
    chk("ar_discard_cnt", 72'(discard_cnt), 72'(0));
`endif
    sys_rst = 1'b0;
    step("ar_sync", 3'b000, IDLE_W, 2'd3);
    step("ar_disc_d2", 3'b100, IDLE_W, 2'd3);
    step("ar_disc_eof", 3'b100, IDLE_W, 2'd3);
`ifdef TXARB_STATS_EN
    chk("ar_discards", 72'(discard_cnt), 72'(2));
`endif
    push(0, sofw(8'h70)); push(0, eofw(8'h70));
    upd();
    step("ar_post_sof", 3'b001, sofw(8'h70), 2'd0);
    step("ar_post_eof", 3'b001, eofw(8'h70), 2'd3);
    step("ar_post_ifg", 3'b000, IDLE_W, 2'd3);
`ifdef TXARB_STATS_EN
    chk("ar_post_frame_cnt", 72'(frame_cnt), 72'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
